// File: rtl/mmio_router.sv
// mmio_router: routes CPU memory-stage accesses either straight through to the
// dcache or, for the low peripheral window, through a single-outstanding request
// FSM that drives one-hot slot requests, waits for the slot ack (with timeout)
// and reports completion / bus error back to the CPU exactly once.
module mmio_router #(
  parameter int unsigned NUM_PERIPH  = 2,
  parameter logic [31:0] PERIPH_BASE = 32'h0000_0000,
  parameter int unsigned PERIPH_SPAN = 16,
  parameter logic [31:0] CACHE_BASE  = 32'h0000_0020,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                       clk,
  input  logic                       n_rst,
  // CPU side
  input  logic                       req,
  input  logic                       lw,
  input  logic [31:0]                addr,
  input  logic [31:0]                data_write,
  input  logic [4:0]                 regD_in,
  output logic                       hit_ack,
  output logic                       miss_store,
  output logic                       load_done_stall,
  output logic                       passive_stall,
  output logic [4:0]                 regD_done,
  output logic [31:0]                data_read,
  output logic                       bus_err,
  // dcache side
  output logic                       ca_req,
  output logic                       ca_lw,
  output logic [31:0]                ca_addr_in,
  output logic [31:0]                ca_write_data,
  output logic [4:0]                 ca_regD_in,
  input  logic                       ca_hit,
  input  logic                       ca_miss_send,
  input  logic                       ca_load_done_stall,
  input  logic                       ca_passive_stall,
  input  logic [4:0]                 ca_regD_out,
  input  logic [31:0]                ca_read_data,
  // peripheral side
  output logic [NUM_PERIPH-1:0]      pr_req,
  output logic                       pr_lw,
  output logic [31:0]                pr_addr,
  output logic [31:0]                pr_write_data,
  input  logic [NUM_PERIPH-1:0]      pr_ack,
  input  logic [32*NUM_PERIPH-1:0]   pr_read_data
);

  localparam int unsigned SW = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;
  localparam int unsigned SH = $clog2(PERIPH_SPAN);
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [31:0]   REGION   = 32'(NUM_PERIPH * PERIPH_SPAN);
  localparam logic [31:0]   OFF_MASK = 32'(PERIPH_SPAN - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREQ = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          lw_q, lw_d;
  logic          err_q, err_d;
  logic [SW-1:0] idx_q, idx_d;
  logic [31:0]   off_q, off_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [32:0]         rel_s;
  logic                dec_cache_s;
  logic                dec_slot_s;
  logic                dec_unmapped_s;
  logic [SW-1:0]       dec_idx_s;
  logic [31:0]         dec_off_s;
  logic                sel_ack_s;
  logic [31:0]         sel_rdata_s;
  logic [NUM_PERIPH-1:0] onehot_s;
  logic                done_fire_s;
  logic                idle_cache_s;

  // Address decode; the 33-bit subtraction's borrow flags addresses below the window.
  always_comb begin
    rel_s       = {1'b0, addr} - {1'b0, PERIPH_BASE};
    dec_cache_s = (addr >= CACHE_BASE);
    dec_slot_s  = 1'b0;
    dec_idx_s   = {SW{1'b0}};
    dec_off_s   = 32'd0;
    if (!dec_cache_s && !rel_s[32] && (rel_s[31:0] < REGION)) begin
      dec_slot_s = 1'b1;
      dec_idx_s  = SW'(rel_s[31:0] >> SH);
      dec_off_s  = rel_s[31:0] & OFF_MASK;
    end else begin
      dec_slot_s = 1'b0;
    end
    dec_unmapped_s = !dec_cache_s && !dec_slot_s;
  end

  // Select ack/data of the latched slot and build its one-hot request vector.
  always_comb begin
    sel_ack_s   = 1'b0;
    sel_rdata_s = 32'd0;
    onehot_s    = {NUM_PERIPH{1'b0}};
    for (int i = 0; i < NUM_PERIPH; i++) begin
      onehot_s[i] = (idx_q == SW'(i));
      sel_ack_s   = onehot_s[i] ? pr_ack[i] : sel_ack_s;
      sel_rdata_s = onehot_s[i] ? pr_read_data[32*i +: 32] : sel_rdata_s;
    end
  end

  // DONE completes unless a peripheral load must wait out the dcache load-done stall.
  assign done_fire_s = (state_q == S_DONE) && !(lw_q && ca_load_done_stall);

  // Next-state logic for the peripheral transaction FSM and its latches.
  always_comb begin
    state_d = state_q;
    lw_d    = lw_q;
    err_d   = err_q;
    idx_d   = idx_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req && dec_slot_s && !ca_load_done_stall) begin
          state_d = S_PREQ;
          lw_d    = lw;
          idx_d   = dec_idx_s;
          off_d   = dec_off_s;
          wdata_d = data_write;
          rdata_d = 32'd0;
          err_d   = 1'b0;
          cnt_d   = {CW{1'b0}};
        end else if (req && dec_unmapped_s) begin
          state_d = S_DONE;
          lw_d    = lw;
          rdata_d = 32'd0;
          err_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREQ: begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (sel_ack_s) begin
          // An ack arriving in the timeout cycle still counts as success.
          state_d = S_DONE;
          err_d   = 1'b0;
          rdata_d = lw_q ? sel_rdata_s : 32'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = 32'd0;
        end else begin
          state_d = S_PREQ;
        end
      end
      S_DONE: begin
        if (done_fire_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latch registers; async reset returns to IDLE and drops pr_req at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      lw_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= {SW{1'b0}};
      off_q   <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      lw_q    <= lw_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // dcache sees CPU traffic only while the FSM is idle and the address is cacheable.
  assign idle_cache_s  = (state_q == S_IDLE) && dec_cache_s;
  assign ca_req        = idle_cache_s ? req        : 1'b0;
  assign ca_lw         = idle_cache_s ? lw         : 1'b0;
  assign ca_addr_in    = idle_cache_s ? addr       : 32'd0;
  assign ca_write_data = idle_cache_s ? data_write : 32'd0;
  assign ca_regD_in    = idle_cache_s ? regD_in    : 5'd0;

  // Peripheral bus is driven from the latches only while a request is in flight.
  assign pr_req        = (state_q == S_PREQ) ? onehot_s : {NUM_PERIPH{1'b0}};
  assign pr_lw         = (state_q == S_PREQ) ? lw_q     : 1'b0;
  assign pr_addr       = (state_q == S_PREQ) ? off_q    : 32'd0;
  assign pr_write_data = (state_q == S_PREQ) ? wdata_q  : 32'd0;

  // CPU status: dcache status passes through, FSM completion merged in.
  assign miss_store      = ca_miss_send;
  assign load_done_stall = ca_load_done_stall;
  assign regD_done       = ca_load_done_stall ? ca_regD_out : 5'd0;
  assign passive_stall   = ca_passive_stall | (state_q != S_IDLE);
  assign hit_ack         = ca_hit | done_fire_s;
  assign bus_err         = done_fire_s & err_q;
  assign data_read       = (ca_load_done_stall | ca_hit) ? ca_read_data :
                           (done_fire_s ? rdata_q : 32'd0);

endmodule

// File: tb/tb_mmio_router.sv
// Testbench for mmio_router: table of idle-state pass-through vectors, directed
// multi-cycle sequences, then random traffic against a transaction-level model.
// CACHE_BASE is moved to 0x40 so that 0x20..0x3F is an unmapped hole.
module tb_mmio_router;
  localparam int NP = 2;
  localparam int SPAN = 16;
  localparam int TO = 64;
  localparam logic [31:0] CBASE = 32'h0000_0040;

  logic clk = 1'b0;
  logic n_rst;
  logic req, lw;
  logic [31:0] addr, data_write;
  logic [4:0] regD_in;
  logic hit_ack, miss_store, load_done_stall, passive_stall, bus_err;
  logic [4:0] regD_done;
  logic [31:0] data_read;
  logic ca_req, ca_lw;
  logic [31:0] ca_addr_in, ca_write_data;
  logic [4:0] ca_regD_in;
  logic ca_hit, ca_miss_send, ca_load_done_stall, ca_passive_stall;
  logic [4:0] ca_regD_out;
  logic [31:0] ca_read_data;
  logic [NP-1:0] pr_req;
  logic pr_lw;
  logic [31:0] pr_addr, pr_write_data;
  logic [NP-1:0] pr_ack;
  logic [32*NP-1:0] pr_read_data;

  int tests = 0;
  int fails = 0;

  mmio_router #(.NUM_PERIPH(NP), .PERIPH_BASE(32'h0), .PERIPH_SPAN(SPAN),
                .CACHE_BASE(CBASE), .TIMEOUT(TO)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .lw(lw), .addr(addr),
    .data_write(data_write), .regD_in(regD_in), .hit_ack(hit_ack),
    .miss_store(miss_store), .load_done_stall(load_done_stall),
    .passive_stall(passive_stall), .regD_done(regD_done), .data_read(data_read),
    .bus_err(bus_err), .ca_req(ca_req), .ca_lw(ca_lw), .ca_addr_in(ca_addr_in),
    .ca_write_data(ca_write_data), .ca_regD_in(ca_regD_in), .ca_hit(ca_hit),
    .ca_miss_send(ca_miss_send), .ca_load_done_stall(ca_load_done_stall),
    .ca_passive_stall(ca_passive_stall), .ca_regD_out(ca_regD_out),
    .ca_read_data(ca_read_data), .pr_req(pr_req), .pr_lw(pr_lw),
    .pr_addr(pr_addr), .pr_write_data(pr_write_data), .pr_ack(pr_ack),
    .pr_read_data(pr_read_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic quiet();
    req = 1'b0; lw = 1'b0; addr = 32'd0; data_write = 32'd0; regD_in = 5'd0;
    ca_hit = 1'b0; ca_miss_send = 1'b0; ca_load_done_stall = 1'b0;
    ca_passive_stall = 1'b0; ca_regD_out = 5'd0; ca_read_data = 32'd0;
    pr_ack = '0; pr_read_data = '0;
  endtask

  typedef struct {
    logic req, lw;
    logic [31:0] addr, wd;
    logic hit, lds, ps;
    logic [31:0] rd;
    logic [4:0] rdo;
    logic e_ca_req;
    logic [31:0] e_ca_addr;
    logic e_hit;
    logic [31:0] e_dr;
    logic e_ps;
    logic [4:0] e_regd;
  } tvec_t;

  tvec_t tv[6];

  // Transaction-level reference model.
  bit m_busy, m_done, m_lw, m_err;
  int m_slot, m_wait;
  logic [31:0] m_off, m_wd, m_rd;

  function automatic int kind_of(input logic [31:0] a);
    if (a >= CBASE) return 0;               // cache
    else if (a < 32'(NP * SPAN)) return 1;  // slot
    else return 2;                           // unmapped
  endfunction

  initial begin
    int npr, nhit, cyc;
    bit seen;
    quiet();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    settle();
    chk("reset pr_req", pr_req, 0);
    chk("reset hit_ack", hit_ack, 0);
    chk("reset bus_err", bus_err, 0);
    chk("reset passive_stall", passive_stall, 0);
    chk("reset data_read", data_read, 0);

    // ---- table: idle-state cache pass-through / decode ----
    tv[0] = '{1'b1, 1'b0, 32'h100, 32'hCAFE, 1'b1, 1'b0, 1'b0, 32'h77, 5'd0,
              1'b1, 32'h100, 1'b1, 32'h77, 1'b0, 5'd0};
    tv[1] = '{1'b1, 1'b1, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1, 32'h55, 5'd0,
              1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 5'd0};
    tv[2] = '{1'b0, 1'b0, 32'h3F, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0,
              1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0};
    tv[3] = '{1'b1, 1'b1, 32'h14, 32'h0, 1'b0, 1'b1, 1'b0, 32'h99, 5'd9,
              1'b0, 32'h0, 1'b0, 32'h99, 1'b0, 5'd9};
    tv[4] = '{1'b0, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0, 32'h1, 5'd3,
              1'b0, 32'h200, 1'b0, 32'h0, 1'b0, 5'd0};
    tv[5] = '{1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 5'd0,
              1'b1, 32'hFFFF_FFF0, 1'b0, 32'h0, 1'b1, 5'd0};
    for (int i = 0; i < 6; i++) begin
      go();
      req = tv[i].req; lw = tv[i].lw; addr = tv[i].addr; data_write = tv[i].wd;
      ca_hit = tv[i].hit; ca_load_done_stall = tv[i].lds;
      ca_passive_stall = tv[i].ps; ca_read_data = tv[i].rd; ca_regD_out = tv[i].rdo;
      settle();
      chk($sformatf("tv%0d ca_req", i), ca_req, tv[i].e_ca_req);
      chk($sformatf("tv%0d ca_addr_in", i), ca_addr_in, tv[i].e_ca_addr);
      chk($sformatf("tv%0d hit_ack", i), hit_ack, tv[i].e_hit);
      chk($sformatf("tv%0d data_read", i), data_read, tv[i].e_dr);
      chk($sformatf("tv%0d passive_stall", i), passive_stall, tv[i].e_ps);
      chk($sformatf("tv%0d regD_done", i), regD_done, tv[i].e_regd);
      chk($sformatf("tv%0d pr_req", i), pr_req, 0);
    end
    go(); quiet(); settle();

    // ---- store 0x14 / 0xA5, ack[1] at cycle 3 ----
    nhit = 0;
    for (int c = 0; c <= 5; c++) begin
      go();
      quiet();
      if (c <= 4) begin req = 1'b1; lw = 1'b0; addr = 32'h14; data_write = 32'hA5; end
      if (c == 3) pr_ack = 2'b10;
      settle();
      if (hit_ack) nhit++;
      if (c >= 1 && c <= 3) begin
        chk($sformatf("st c%0d pr_req", c), pr_req, 2'b10);
        chk($sformatf("st c%0d pr_addr", c), pr_addr, 32'h4);
        chk($sformatf("st c%0d pr_write_data", c), pr_write_data, 32'hA5);
      end
      if (c == 4) chk("st hit_ack@4", hit_ack, 1);
      if (c == 4) chk("st bus_err@4", bus_err, 0);
    end
    chk("st hit_ack count", nhit, 1);

    // ---- load 0x04, ack @2 data 0x1234, load_done_stall cycles 3..5 ----
    npr = 0; nhit = 0;
    for (int c = 0; c <= 7; c++) begin
      go();
      quiet();
      if (c <= 6) begin req = 1'b1; lw = 1'b1; addr = 32'h04; regD_in = 5'd5; end
      if (c == 2) begin pr_ack = 2'b01; pr_read_data = {32'h0, 32'h1234}; end
      if (c >= 3 && c <= 5) begin
        ca_load_done_stall = 1'b1; ca_read_data = 32'hDEAD; ca_regD_out = 5'd7;
      end
      settle();
      if (pr_req != 0) npr++;
      if (hit_ack) nhit++;
      if (c == 4) begin
        chk("ld stall hit_ack", hit_ack, 0);
        chk("ld stall data_read", data_read, 32'hDEAD);
        chk("ld stall regD_done", regD_done, 5'd7);
      end
      if (c == 6) begin
        chk("ld hit_ack@6", hit_ack, 1);
        chk("ld data_read@6", data_read, 32'h1234);
      end
    end
    chk("ld pr_req cycles", npr, 2);
    chk("ld hit_ack count", nhit, 1);

    // ---- unmapped load 0x30: hit_ack+bus_err @1 ----
    go(); quiet(); req = 1'b1; lw = 1'b1; addr = 32'h30; settle();
    chk("um c0 hit_ack", hit_ack, 0);
    go(); quiet(); settle();
    chk("um c1 hit_ack", hit_ack, 1);
    chk("um c1 bus_err", bus_err, 1);
    chk("um c1 pr_req", pr_req, 0);
    go(); settle();
    chk("um c2 hit_ack", hit_ack, 0);

    // ---- timeout on slot 0 ----
    go(); quiet(); req = 1'b1; lw = 1'b1; addr = 32'h08;
    pr_read_data = {32'hFFFF_FFFF, 32'hFFFF_FFFF}; settle();
    npr = 0; seen = 0; cyc = 0;
    for (int c = 1; c <= 200; c++) begin
      go(); req = 1'b0; settle();
      if (pr_req == 2'b01) npr++;
      if (hit_ack) begin seen = 1; cyc = c; break; end
    end
    chk("to hit_ack seen", seen, 1);
    chk("to hit_ack cycle", cyc, TO + 1);
    chk("to pr_req cycles", npr, TO);
    chk("to bus_err", bus_err, 1);
    chk("to data_read", data_read, 0);

    // ---- slot 0 load, stray ack[1], ack[0] @5 ----
    nhit = 0;
    for (int c = 0; c <= 6; c++) begin
      go(); quiet();
      pr_read_data = {32'h2222_2222, 32'h1111_1111};
      if (c == 0) begin req = 1'b1; lw = 1'b1; addr = 32'h0C; end
      if (c == 2 || c == 3) pr_ack = 2'b10;
      if (c == 5) pr_ack = 2'b01;
      settle();
      if (c >= 1 && c <= 5) begin
        chk($sformatf("sa c%0d pr_req", c), pr_req, 2'b01);
        if (hit_ack) nhit++;
      end
      if (c == 6) begin
        chk("sa hit_ack@6", hit_ack, 1);
        chk("sa data_read@6", data_read, 32'h1111_1111);
      end
    end
    chk("sa early hit_ack", nhit, 0);

    // ---- reset during P_REQ ----
    go(); quiet(); req = 1'b1; lw = 1'b0; addr = 32'h18; settle();
    go(); quiet(); settle();
    go(); settle();
    chk("rst pre pr_req", pr_req, 2'b10);
    #1 n_rst = 1'b0; pr_ack = 2'b10;
    #1;
    chk("rst pr_req async", pr_req, 0);
    chk("rst hit_ack", hit_ack, 0);
    go(); go(); #2 n_rst = 1'b1; pr_ack = 2'b00;
    nhit = 0;
    for (int c = 0; c < 4; c++) begin
      go(); settle();
      if (hit_ack) nhit++;
    end
    chk("rst no hit_ack", nhit, 0);
    chk("rst idle", passive_stall, 0);

    // ---- random traffic vs model ----
    m_busy = 0; m_done = 0; m_lw = 0; m_err = 0; m_slot = 0; m_wait = 0;
    m_off = 0; m_wd = 0; m_rd = 0;
    for (int n = 0; n < 3000; n++) begin
      int k;
      bit idle, fire;
      logic [NP-1:0] e_preq;
      logic [31:0] e_dr;
      go();
      k = $urandom_range(0, 2);
      if (k == 0) addr = CBASE + 32'($urandom_range(0, 32'h1C0));
      else if (k == 1) addr = 32'($urandom_range(0, NP * SPAN - 1));
      else addr = 32'(NP * SPAN) + 32'($urandom_range(0, 31));
      req = ($urandom_range(0, 2) == 0);
      lw = ($urandom_range(0, 1) == 1);
      data_write = $urandom;
      regD_in = 5'($urandom);
      ca_hit = ($urandom_range(0, 7) == 0);
      ca_load_done_stall = ($urandom_range(0, 5) == 0);
      ca_passive_stall = ($urandom_range(0, 7) == 0);
      ca_read_data = $urandom;
      ca_regD_out = 5'($urandom);
      pr_ack = NP'($urandom) & NP'($urandom);
      pr_read_data = {$urandom, $urandom};
      settle();
      idle = !m_busy && !m_done;
      fire = m_done && !(m_lw && ca_load_done_stall);
      e_preq = m_busy ? NP'(1 << m_slot) : '0;
      e_dr = (ca_load_done_stall || ca_hit) ? ca_read_data : (fire ? m_rd : 32'd0);
      chk("rnd pr_req", pr_req, e_preq);
      chk("rnd pr_addr", pr_addr, m_busy ? m_off : 32'd0);
      chk("rnd pr_write_data", pr_write_data, m_busy ? m_wd : 32'd0);
      chk("rnd pr_lw", pr_lw, m_busy ? m_lw : 1'b0);
      chk("rnd hit_ack", hit_ack, ca_hit || fire);
      chk("rnd bus_err", bus_err, fire && m_err);
      chk("rnd data_read", data_read, e_dr);
      chk("rnd passive_stall", passive_stall, ca_passive_stall || !idle);
      chk("rnd ca_req", ca_req, (idle && k == 0) ? req : 1'b0);
      chk("rnd ca_addr_in", ca_addr_in, (idle && k == 0) ? addr : 32'd0);
      chk("rnd regD_done", regD_done, ca_load_done_stall ? ca_regD_out : 5'd0);
      // advance model with the inputs present at the coming edge
      if (idle) begin
        if (req && k == 1 && !ca_load_done_stall) begin
          m_busy = 1; m_lw = lw; m_slot = int'(addr) / SPAN;
          m_off = addr % SPAN; m_wd = data_write; m_wait = 0;
        end else if (req && k == 2) begin
          m_done = 1; m_lw = lw; m_err = 1; m_rd = 0;
        end
      end else if (m_busy) begin
        m_wait++;
        if (pr_ack[m_slot]) begin
          m_busy = 0; m_done = 1; m_err = 0;
          m_rd = m_lw ? pr_read_data[32*m_slot +: 32] : 32'd0;
        end else if (m_wait == TO) begin
          m_busy = 0; m_done = 1; m_err = 1; m_rd = 0;
        end
      end else if (fire) begin
        m_done = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
